// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_e;

  // Bits needed to hold 0..value without wrapping.
  function automatic int cnt_width(input int unsigned value);
    return $clog2(value) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer for a signal asynchronous to clk.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // Shift the raw input through the flop chain; the last flop is the safe copy.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge neighbour.
    if (reset) stages <= {STAGES{RESET_VAL}};
    else       stages <= {stages[STAGES-2:0], d};
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervisor that resets the PLL, qualifies its lock and gates the system reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  localparam int TIMER_MAX = (LOCK_TIMEOUT > STABLE_CYCLES)
                             ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
                             : ((STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES);
  localparam int TIMER_W = cnt_width(TIMER_MAX);

  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] STABLE_LOAD = TIMER_W'(STABLE_CYCLES);
  localparam logic [2:0]         RETRY_LIMIT = 3'(MAX_RETRIES);

  seq_state_e         cur_state, nxt_state;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [2:0]         retry_nxt, retry_inc;
  logic [7:0]         loss_nxt;
  logic               lock_s;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk  (clkin),
    .reset(reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // retry_cnt never exceeds RETRY_LIMIT outside FAIL, so this cannot wrap.
  assign retry_inc = retry_cnt + 3'd1;

  // Next-state, timer and counter decisions from the synchronized lock.
  // PLL_RST counts up from 0 (its entry/reset value); the other states count down.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path infers a latch.
    nxt_state = cur_state;
    timer_nxt = timer;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    unique case (cur_state)
      PLL_RST: begin
        if (timer == RST_LAST) begin
          nxt_state = WAIT_LOCK;
          timer_nxt = LOCK_LOAD;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          nxt_state = STABLE;
          timer_nxt = STABLE_LOAD;
        end else if (timer == TIMER_ONE) begin
          retry_nxt = retry_inc;
          nxt_state = (retry_inc == RETRY_LIMIT) ? FAIL : PLL_RST;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          retry_nxt = retry_inc;
          nxt_state = (retry_inc == RETRY_LIMIT) ? FAIL : PLL_RST;
          timer_nxt = '0;
        end else if (timer == TIMER_ONE) begin
          nxt_state = RUN;
          retry_nxt = '0;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          nxt_state = PLL_RST;
          timer_nxt = '0;
          if (loss_cnt != 8'd255) loss_nxt = loss_cnt + 8'd1;
        end
      end
      FAIL: begin
        // Absorbing until reset; lock is deliberately ignored here.
      end
      default: begin
        nxt_state = PLL_RST;
        timer_nxt = '0;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they change with it.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cur_state <= PLL_RST;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      pll_reset <= (nxt_state == PLL_RST) || (nxt_state == FAIL);
      sys_rst   <= (nxt_state != RUN);
      locked    <= (nxt_state == RUN);
      fail      <= (nxt_state == FAIL);
    end
  end

  assign state = cur_state;

endmodule
